// File: rtl/csa_pkg.sv
// ============================================================================
// Module   : csa_pkg
// Purpose  : Shared constants, flag bundle and configuration check for the
//            pipelined carry-select adder/subtractor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package csa_pkg;

  localparam int CSA_WIDTH  = 32;
  localparam int CSA_BLOCK  = 4;
  localparam int CSA_STAGES = 2;

  typedef struct packed {
    logic cout;
    logic overflow;
    logic is_less_than;
    logic is_less_than_u;
    logic is_not_equal;
  } csa_flags_t;

  // The operand must split evenly into STAGES slices of whole BLOCK cells.
  function automatic bit csa_cfg_ok(input int width, input int block, input int stages);
    return (stages >= 1) && (block >= 1) && (width >= block * stages) &&
           ((width % (block * stages)) == 0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/csa_select_cell.sv
// ============================================================================
// Module   : csa_select_cell
// Purpose  : BLOCK-bit carry-select cell: both carry-in sums precomputed,
//            late carry picks one. Also returns the carry into the cell MSB.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module csa_select_cell #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [BLOCK:0] w_sum0;
  logic [BLOCK:0] w_sum1;

  assign w_sum0 = {1'b0, a} + {1'b0, b};
  assign w_sum1 = {1'b0, a} + {1'b0, b} + {{BLOCK{1'b0}}, 1'b1};

  assign sum  = cin ? w_sum1[BLOCK-1:0] : w_sum0[BLOCK-1:0];
  assign cout = cin ? w_sum1[BLOCK]     : w_sum0[BLOCK];

  // Carry into the top bit recovered from the selected sum bit.
  assign cmsb = sum[BLOCK-1] ^ a[BLOCK-1] ^ b[BLOCK-1];

endmodule

`default_nettype wire

// File: rtl/csa_addsub_pipe.sv
// ============================================================================
// Module   : csa_addsub_pipe
// Purpose  : Pipelined carry-select adder/subtractor with compare flags and
//            a valid/ready handshake using one global advance signal.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module csa_addsub_pipe
  import csa_pkg::*;
#(
  parameter int WIDTH  = CSA_WIDTH,
  parameter int BLOCK  = CSA_BLOCK,
  parameter int STAGES = CSA_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             is_less_than,
  output logic             is_less_than_u,
  output logic             is_not_equal
);

  localparam int c_sw   = WIDTH / STAGES;
  localparam int c_nc   = c_sw / BLOCK;
  localparam int c_last = STAGES - 1;

  if (!csa_cfg_ok(WIDTH, BLOCK, STAGES)) begin : g_cfg_error
    $error("csa_addsub_pipe: WIDTH must be a multiple of BLOCK*STAGES");
  end

  // Register level 0 captures the effective operands; level k+1 holds the
  // result of slice k. Level STAGES drives the outputs.
  logic [WIDTH-1:0] r_a   [STAGES+1];
  logic [WIDTH-1:0] r_b   [STAGES+1];
  logic [WIDTH-1:0] r_sum [STAGES+1];
  logic             r_c   [STAGES+1];
  logic             r_sub [STAGES+1];
  logic             r_nz  [STAGES+1];
  logic             r_v   [STAGES+1];
  csa_flags_t       r_flags;

  logic [WIDTH-1:0] w_sum_out [STAGES];
  logic             w_c_out   [STAGES];
  logic             w_cmsb    [STAGES];
  logic             w_nz_out  [STAGES];
  csa_flags_t       w_flags;
  logic             w_adv;

  assign w_adv = !r_v[STAGES] || out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [c_nc:0]   w_cc;
    logic            w_cm [c_nc];
    logic [c_sw-1:0] w_slice;

    assign w_cc[0] = r_c[k];

    for (genvar j = 0; j < c_nc; j++) begin : g_cell
      csa_select_cell #(
        .BLOCK(BLOCK)
      ) u_cell (
        .a    (r_a[k][k*c_sw + j*BLOCK +: BLOCK]),
        .b    (r_b[k][k*c_sw + j*BLOCK +: BLOCK]),
        .cin  (w_cc[j]),
        .sum  (w_slice[j*BLOCK +: BLOCK]),
        .cout (w_cc[j+1]),
        .cmsb (w_cm[j])
      );
    end

    // Slice bits above the completed region are still zero in r_sum.
    assign w_sum_out[k] = r_sum[k] | (WIDTH'(w_slice) << (k * c_sw));
    assign w_c_out[k]   = w_cc[c_nc];
    assign w_cmsb[k]    = w_cm[c_nc-1];
    assign w_nz_out[k]  = r_nz[k] | (|w_slice);
  end

  always_comb begin
    w_flags                = '0;
    w_flags.cout           = w_c_out[c_last];
    w_flags.overflow       = w_cmsb[c_last] ^ w_c_out[c_last];
    w_flags.is_less_than   = w_sum_out[c_last][WIDTH-1] ^ w_flags.overflow;
    w_flags.is_less_than_u = r_sub[c_last] & ~w_c_out[c_last];
    w_flags.is_not_equal   = w_nz_out[c_last];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k <= STAGES; k++) begin
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_sum[k] <= '0;
        r_c[k]   <= 1'b0;
        r_sub[k] <= 1'b0;
        r_nz[k]  <= 1'b0;
        r_v[k]   <= 1'b0;
      end
      r_flags <= '0;
    end else if (w_adv) begin
      r_a[0]   <= a;
      r_b[0]   <= op_sub ? ~b : b;
      r_sum[0] <= '0;
      r_c[0]   <= op_sub | cin;
      r_sub[0] <= op_sub;
      r_nz[0]  <= 1'b0;
      r_v[0]   <= in_valid;
      for (int k = 0; k < STAGES; k++) begin
        r_a[k+1]   <= r_a[k];
        r_b[k+1]   <= r_b[k];
        r_sum[k+1] <= w_sum_out[k];
        r_c[k+1]   <= w_c_out[k];
        r_sub[k+1] <= r_sub[k];
        r_nz[k+1]  <= w_nz_out[k];
        r_v[k+1]   <= r_v[k];
      end
      r_flags <= w_flags;
    end
  end

  assign in_ready       = w_adv;
  assign out_valid      = r_v[STAGES];
  assign sum            = r_sum[STAGES];
  assign cout           = r_flags.cout;
  assign overflow       = r_flags.overflow;
  assign is_less_than   = r_flags.is_less_than;
  assign is_less_than_u = r_flags.is_less_than_u;
  assign is_not_equal   = r_flags.is_not_equal;

endmodule

`default_nettype wire

// File: tb/tb_csa_addsub_pipe.sv
// ============================================================================
// Module   : tb_csa_addsub_pipe
// Purpose  : Self-checking bench for csa_addsub_pipe (32/4/2 configuration).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_csa_addsub_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        op_sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout;
  logic        overflow;
  logic        is_less_than;
  logic        is_less_than_u;
  logic        is_not_equal;

  csa_addsub_pipe #(
    .WIDTH (32),
    .BLOCK (4),
    .STAGES(2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .a             (a),
    .b             (b),
    .cin           (cin),
    .op_sub        (op_sub),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .sum           (sum),
    .cout          (cout),
    .overflow      (overflow),
    .is_less_than  (is_less_than),
    .is_less_than_u(is_less_than_u),
    .is_not_equal  (is_not_equal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        lt;
    logic        ltu;
    logic        ne;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    res_t        exp;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // Reference: plain signed/unsigned arithmetic on the operands.
  function automatic res_t model(input logic [31:0] a_i, input logic [31:0] b_i,
                                 input logic cin_i, input logic sub_i);
    res_t        r;
    longint      s;
    logic [32:0] u;
    r = '0;
    if (sub_i) begin
      s      = longint'($signed(a_i)) - longint'($signed(b_i));
      r.sum  = a_i - b_i;
      r.cout = (a_i >= b_i);
      r.ltu  = (a_i < b_i);
    end else begin
      s      = longint'($signed(a_i)) + longint'($signed(b_i)) + longint'(cin_i);
      u      = {1'b0, a_i} + {1'b0, b_i} + {32'd0, cin_i};
      r.sum  = u[31:0];
      r.cout = u[32];
      r.ltu  = 1'b0;
    end
    r.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    if (sub_i) r.lt = ($signed(a_i) < $signed(b_i));
    else       r.lt = r.sum[31] ^ r.ovf;
    r.ne = (r.sum != 32'd0);
    return r;
  endfunction

  function automatic res_t dut_res();
    return {sum, cout, overflow, is_less_than, is_less_than_u, is_not_equal};
  endfunction

  function automatic vec_t mkv(input logic [31:0] a_i, input logic [31:0] b_i,
                               input logic cin_i, input logic sub_i, input res_t e);
    vec_t v;
    v.a = a_i; v.b = b_i; v.cin = cin_i; v.sub = sub_i; v.exp = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, got, exp);
    end
  endtask

  // One op into an idle pipe; result must appear exactly two edges later.
  task automatic run_single(input vec_t v, input string name);
    int lat;
    out_ready = 1'b1;
    a = v.a; b = v.b; cin = v.cin; op_sub = v.sub;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, " latency"}, 64'(lat), 64'd2);
    check({name, " result"}, 64'(dut_res()), 64'(v.exp));
    @(posedge clk); #1;
  endtask

  vec_t        vecs [16];
  logic [31:0] s_a [8];
  logic [31:0] s_b [8];
  logic        s_cin [8];
  logic        s_sub [8];
  res_t        expq [$];

  initial begin
    int          issued;
    int          got;
    int          cyc;
    int          stall_cnt;
    int          idle_v;
    logic        stalled_prev;
    logic [63:0] snap;
    logic [63:0] cur;
    res_t        e;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; op_sub = 1'b0;

    // {a, b, cin, sub} -> {sum, cout, ovf, lt, ltu, ne}
    vecs[0] = mkv(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, {32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
    vecs[1] = mkv(32'h00000005, 32'h00000005, 1'b0, 1'b1, {32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs[2] = mkv(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b1, {32'hFFFFFFFE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1});
    vecs[3] = mkv(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, {32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs[4] = mkv(32'h00000001, 32'h00000002, 1'b0, 1'b1, {32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1});
    vecs[5] = mkv(32'h80000000, 32'h00000001, 1'b0, 1'b1, {32'h7FFFFFFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1});
    vecs[6] = mkv(32'h0000000A, 32'h00000003, 1'b1, 1'b1, {32'h00000007, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
    vecs[7] = mkv(32'h80000000, 32'h80000000, 1'b0, 1'b0, {32'h00000000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
    for (int i = 8; i < 16; i++) begin
      logic [31:0] ra, rb;
      logic        rc, rs;
      ra = $urandom; rb = (i == 8) ? ra : $urandom;
      rc = 1'($urandom_range(1)); rs = (i < 12) ? 1'b1 : 1'($urandom_range(1));
      vecs[i] = mkv(ra, rb, rc, rs, model(ra, rb, rc, rs));
    end

    // Reset state, during and just after reset
    @(posedge clk); @(posedge clk); #1;
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset outputs", 64'(dut_res()), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post-reset out_valid", 64'(out_valid), 64'd0);
    check("post-reset in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 16; i++) run_single(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back stream with a 3-cycle consumer stall
    for (int i = 0; i < 8; i++) begin
      s_a[i] = $urandom; s_b[i] = $urandom;
      s_cin[i] = 1'($urandom_range(1)); s_sub[i] = 1'($urandom_range(1));
    end
    issued = 0; got = 0; cyc = 0; stall_cnt = 0; stalled_prev = 1'b0; snap = '0;
    while (got < 8 && cyc < 100) begin
      out_ready = !(cyc >= 4 && cyc < 7);
      if (issued < 8) begin
        in_valid = 1'b1;
        a = s_a[issued]; b = s_b[issued]; cin = s_cin[issued]; op_sub = s_sub[issued];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      cur = {26'd0, out_valid, dut_res()};
      if (stalled_prev) check("stall hold", cur, snap);
      if (out_valid && !out_ready) begin
        check("stall in_ready", 64'(in_ready), 64'd0);
        stall_cnt++;
        stalled_prev = 1'b1;
        snap = cur;
      end else begin
        stalled_prev = 1'b0;
      end
      if (in_valid && in_ready) begin
        expq.push_back(model(s_a[issued], s_b[issued], s_cin[issued], s_sub[issued]));
        issued++;
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          check("stream extra result", 64'd1, 64'd0);
        end else begin
          e = expq.pop_front();
          check($sformatf("stream%0d", got), 64'(dut_res()), 64'(e));
        end
        got++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    check("stream count", 64'(got), 64'd8);
    check("stream stall cycles", 64'(stall_cnt), 64'd3);

    // Asynchronous reset with two ops in flight
    out_ready = 1'b0;
    a = 32'h12345678; b = 32'h11111111; cin = 1'b0; op_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 32'h00000009; b = 32'h00000004; op_sub = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("in-flight out_valid", 64'(out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("async reset out_valid", 64'(out_valid), 64'd0);
    check("async reset in_ready", 64'(in_ready), 64'd1);
    check("async reset outputs", 64'(dut_res()), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    idle_v = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (out_valid) idle_v++;
      @(posedge clk); #1;
    end
    check("no stale result", 64'(idle_v), 64'd0);
    run_single(mkv(32'h00000010, 32'h00000020, 1'b1, 1'b0, model(32'h00000010, 32'h00000020, 1'b1, 1'b0)),
               "after reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/csa_addsub_pipe.md
# csa_addsub_pipe

Parametrised, pipelined carry-select adder/subtractor with compare flags, the successor to the team's fixed 32-bit combinational carry-select adder. It splits the operand width into `STAGES` pipeline slices. Each slice is built from `BLOCK`-bit carry-select cells, and the carry and operand skew are registered between slices. A valid/ready handshake with backpressure wraps the pipeline. It sits in the execute stage and feeds add/sub results, overflow, signed/unsigned less-than and not-equal flags to the branch and set-less-than logic.

## Interface
- `WIDTH`, 32: operand and result width in bits.
- `BLOCK`, 4: carry-select cell width in bits.
- `STAGES`, 2: number of register stages, ≥1. Requires `WIDTH % (BLOCK*STAGES) == 0`.
- Clocking and reset (already decided): one clock; reset is asynchronous and active-high.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operands valid.
- `in_ready`  out  1  block accepts the operation this cycle.
- `a`  in  WIDTH  operand A.
- `b`  in  WIDTH  operand B.
- `cin`  in  1  carry-in; used for add only.
- `op_sub`  in  1  1 = A−B, 0 = A+B+cin.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `sum`  out  WIDTH  result.
- `cout`  out  1  carry out of the MSB.
- `overflow`  out  1  signed overflow.
- `is_less_than`  out  1  signed A<B; meaningful when `op_sub`=1.
- `is_less_than_u`  out  1  unsigned A<B; meaningful when `op_sub`=1.
- `is_not_equal`  out  1  `sum` ≠ 0.

## Operation
- Effective operands:
  - Sub: `b_eff = ~b`, carry-in = 1, and `cin` is ignored.
  - Add: `b_eff = b`, carry-in = `cin`.
- Slice width is `SW = WIDTH/STAGES`.
  - Stage k computes bits `[k*SW +: SW]`, using the carry registered from stage k−1; stage 0 uses the effective carry-in.
  - Within a slice, cell 0 uses the incoming carry directly.
  - Every other cell computes both carry-0 and carry-1 sums and muxes on the rippled select carry.
- Pipeline registers are skewed:
  - Each stage register holds the completed low result bits, the not-yet-consumed upper operand bits, `op_sub`, the running carry, a running OR of completed sum bits, and a valid bit.
- Flags at the final stage, all registered with `sum`:
  - `overflow` = carry into MSB XOR carry out of MSB.
  - `is_less_than` = `sum[WIDTH-1]` XOR `overflow`.
  - `is_less_than_u` = `op_sub` AND NOT `cout`.
  - `is_not_equal` = running OR of all sum bits.
- Flow control uses a global advance: `adv = !out_valid || out_ready`.
  - `in_ready = adv`.
  - All stages shift when `adv`=1 and hold when `adv`=0.
  - Bubbles (valid=0) shift like data.
- A transfer happens on `in_valid && in_ready` or `out_valid && out_ready`.
  - Input and output transfers in the same cycle are both legal.
  - Results leave in issue order, with no loss or duplication.
- Reset:
  - All valid bits clear immediately, so `out_valid`=0 and `in_ready`=1 once reset is deasserted.
  - `sum` and every flag reset to 0.
  - Operations in flight are discarded. No partial result is ever presented.

## Timing
- Latency: an op accepted at edge n is presented with `out_valid`=1 after edge n+`STAGES` when no stall occurs.
- Throughput: one op per cycle while `out_ready`=1.
- Stall: while `out_valid && !out_ready`, outputs and all stage contents hold stable and `in_ready`=0.
- Critical path per stage: one BLOCK ripple plus `SW/BLOCK` select muxes.

## Structure
- Package `csa_pkg`:
  - default constants `CSA_WIDTH`=32, `CSA_BLOCK`=4, `CSA_STAGES`=2.
  - packed struct `csa_flags_t` {cout, overflow, is_less_than, is_less_than_u, is_not_equal}.
  - elaboration-time check function for the divisibility rule.
- Sub-module `csa_select_cell`, parametrised by `BLOCK`: two BLOCK-bit adders (carry-in 0 and 1) plus a select mux, returning the selected sum, carry out and carry into its MSB.
- Top level: generate loops over stages and cells, stage registers, and handshake logic.

## Test plan
All scenarios use `WIDTH`=32, `BLOCK`=4, `STAGES`=2.
- Add 0x7FFFFFFF+0x00000001, cin=0 -> after 2 cycles: `sum`=0x80000000, `overflow`=1, `cout`=0, `is_not_equal`=1.
- Sub 5−5 -> `sum`=0, `cout`=1, `is_not_equal`=0, `is_less_than`=0, `is_less_than_u`=0.
- Sub 0xFFFFFFFF−0x00000001 -> `sum`=0xFFFFFFFE, `is_less_than`=1, `is_less_than_u`=0, `overflow`=0.
- Add 0xFFFFFFFF+0, cin=1 (full carry through every cell and stage) -> `sum`=0, `cout`=1, `is_not_equal`=0.
- Stream 8 random ops back-to-back with `out_ready` held low for 3 cycles mid-stream:
  - `in_ready`=0 and outputs stable during the stall.
  - All 8 results appear in order and match the reference model.
- Assert `rst` with 2 ops in flight:
  - `out_valid` drops to 0 without waiting for a clock edge.
  - After release, no stale result appears.
  - The next accepted op appears exactly 2 cycles after acceptance.
